// File: rtl/y86_pkg.sv
// y86_pkg: definitions shared by the Y86-64 memory stage.
//   - icode values of the instructions that touch data memory
//   - status codes and the "no register" id
//   - controller state encodings
//   - mem_op_t plus decode_mem_op(): icode -> read/write/address-source
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'b000;
    localparam logic [2:0] STAT_INS = 3'b001;
    localparam logic [2:0] STAT_ADR = 3'b010;
    localparam logic [2:0] STAT_HLT = 3'b100;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    typedef struct packed {
        logic is_wr;
        logic is_rd;
        logic use_vala;
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [3:0] icode);
        mem_op_t op;
        op = '0;
        case (icode)
            I_RMMOVQ, I_CALL, I_PUSHQ: op.is_wr = 1'b1;
            I_MRMOVQ:                  op.is_rd = 1'b1;
            I_RET, I_POPQ: begin
                op.is_rd    = 1'b1;
                op.use_vala = 1'b1;
            end
            default: op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipe_mem_stage_if.sv
// pipe_mem_stage_if: E->M input handshake, M->W output handshake and busy flag.
//   slave  : the memory stage (consumes E->M, produces W)
//   master : the surrounding pipeline (drives E->M, consumes W)
//   Inputs : in_valid, M_icode, M_stat, M_valA, M_valE, M_dstE, M_dstM, insn_limit, out_ready
//   Outputs: in_ready, out_valid, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, mem_busy
interface pipe_mem_stage_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        M_icode;
    logic [2:0]        M_stat;
    logic [DATA_W-1:0] M_valA;
    logic [DATA_W-1:0] M_valE;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;
    logic [ADDR_W-1:0] insn_limit;

    logic              out_valid;
    logic              out_ready;
    logic [2:0]        W_stat;
    logic [3:0]        W_icode;
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [3:0]        W_dstE;
    logic [3:0]        W_dstM;

    logic              mem_busy;

    modport master (
        output in_valid, M_icode, M_stat, M_valA, M_valE, M_dstE, M_dstM, insn_limit, out_ready,
        input  in_ready, out_valid, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, mem_busy
    );

    modport slave (
        input  in_valid, M_icode, M_stat, M_valA, M_valE, M_dstE, M_dstM, insn_limit, out_ready,
        output in_ready, out_valid, W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM, mem_busy
    );
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port data memory, DEPTH words of DATA_W bits, registered read.
//   clk   : clock
//   en    : perform an access this edge
//   we    : 1 = write wdata to word idx, 0 = read word idx into rdata
//   idx   : word index (no byte offset)
//   wdata : store data
//   rdata : read data, updated only by read accesses
// Contents start as word i = i+1 and are never cleared by reset.
module dmem_ram #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4096,
    parameter int IDX_W  = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = DATA_W'(i + 1);
        end
        return m;
    endfunction

    mem_t mem = mem_init();

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: Y86-64 memory stage with data memory and M->W register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_mem_stage_if.slave (E->M handshake in, W register out, mem_busy)
// Parameters: DATA_W word width, ADDR_W byte-address width, DEPTH words, MEM_LAT access latency.
// Build option: MEM_ALIGN_CHECK_EN -- when defined, an access whose byte address
// is not word aligned fails with ADR; otherwise the low bits are dropped.
//
// state     | meaning
// ST_IDLE   | ready for a new instruction (subject to W being free)
// ST_ACCESS | legal memory access in flight, cnt cycles left before completion
// ST_HALTED | a non-AOK status was handed to write-back; frozen until reset
module pipe_mem_stage
    import y86_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 4096,
    parameter int MEM_LAT = 2
) (
    input logic             clk,
    input logic             rst_n,
    pipe_mem_stage_if.slave bus
);

    localparam int BYTES = DATA_W / 8;
    localparam int SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam int AW_X  = (ADDR_W > 32) ? ADDR_W : 33;
    localparam int CMP_W = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;

    mem_op_t           op;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] word_addr;
    logic              oob;
    logic              misalign;
    logic              is_access;
    logic              acc_go;
    logic [2:0]        acc_stat;

    logic              in_ready;
    logic              accept;
    logic              handoff;
    logic              done;
    logic              load_w;

    logic              p_wr;
    logic [IDX_W-1:0]  p_idx;
    logic [DATA_W-1:0] p_wdata;

    logic              ram_en;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    logic              out_valid_q;
    logic [2:0]        w_stat_q;
    logic [3:0]        w_icode_q;
    logic [DATA_W-1:0] w_vale_q;
    logic [3:0]        w_dste_q;
    logic [3:0]        w_dstm_q;
    logic              w_rd_q;
    logic              w_ret_q;
    logic [ADDR_W-1:0] w_lim_q;
    logic              ret_bad;
    logic [2:0]        w_stat;

    always_comb begin
        op        = decode_mem_op(bus.M_icode);
        addr      = op.use_vala ? ADDR_W'(bus.M_valA) : ADDR_W'(bus.M_valE);
        word_addr = addr >> SHIFT;
        oob       = AW_X'(word_addr) >= AW_X'(DEPTH);
`ifdef MEM_ALIGN_CHECK_EN
        misalign  = (addr & ADDR_W'(BYTES - 1)) != '0;
`else
        misalign  = 1'b0;
`endif
        is_access = op.is_rd | op.is_wr;
    end

    always_comb begin
        acc_stat = STAT_AOK;
        acc_go   = 1'b0;
        if (bus.M_stat != STAT_AOK) begin
            acc_stat = bus.M_stat;
        end else if (bus.M_icode == I_HALT) begin
            acc_stat = STAT_HLT;
        end else if (is_access && (oob || misalign)) begin
            acc_stat = STAT_ADR;
        end else begin
            acc_go = is_access;
        end
    end

    // ret target check needs the read word, which only exists once the RAM
    // has registered it, so the final status is resolved on the output side.
    assign ret_bad = w_ret_q && (CMP_W'(ram_q) > CMP_W'(w_lim_q));
    assign w_stat  = ret_bad ? STAT_ADR : w_stat_q;

    // A non-AOK result sitting in W blocks new work: the pipe halts behind it.
    assign in_ready = (state == ST_IDLE) &&
                      (!out_valid_q || (bus.out_ready && (w_stat == STAT_AOK)));
    assign accept   = bus.in_valid && in_ready;
    assign handoff  = out_valid_q && bus.out_ready;

    // The accept cycle is the first access cycle, so ACCESS lasts MEM_LAT-1
    // cycles and MEM_LAT=1 completes on the accept edge itself.
    assign done   = (MEM_LAT > 1) && (state == ST_ACCESS) && (cnt == '0);
    assign load_w = (accept && (!acc_go || (MEM_LAT == 1))) || done;

    // RAM is touched only at completion; gating with rst_n drops a store whose
    // completion edge arrives while reset is held.
    always_comb begin
        if (MEM_LAT == 1) begin
            ram_en    = rst_n && accept && acc_go;
            ram_we    = op.is_wr;
            ram_idx   = word_addr[IDX_W-1:0];
            ram_wdata = bus.M_valA;
        end else begin
            ram_en    = rst_n && done;
            ram_we    = p_wr;
            ram_idx   = p_idx;
            ram_wdata = p_wdata;
        end
    end

    dmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_dmem (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handoff && (w_stat != STAT_AOK)) begin
                        state <= ST_HALTED;
                    end else if (accept && acc_go && (MEM_LAT > 1)) begin
                        state <= ST_ACCESS;
                        cnt   <= CNT_W'(MEM_LAT - 2);
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_wr    <= 1'b0;
            p_idx   <= '0;
            p_wdata <= '0;
        end else if (accept && acc_go) begin
            p_wr    <= op.is_wr;
            p_idx   <= word_addr[IDX_W-1:0];
            p_wdata <= bus.M_valA;
        end
    end

    // W fields load on accept (W is free or being handed off that edge);
    // out_valid alone marks when they become meaningful.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            w_stat_q    <= STAT_AOK;
            w_icode_q   <= 4'h0;
            w_vale_q    <= '0;
            w_dste_q    <= RNONE;
            w_dstm_q    <= RNONE;
            w_rd_q      <= 1'b0;
            w_ret_q     <= 1'b0;
            w_lim_q     <= '0;
        end else begin
            if (handoff) begin
                out_valid_q <= 1'b0;
            end
            if (load_w) begin
                out_valid_q <= 1'b1;
            end
            if (accept) begin
                w_stat_q  <= acc_stat;
                w_icode_q <= bus.M_icode;
                w_vale_q  <= bus.M_valE;
                w_dste_q  <= bus.M_dstE;
                w_dstm_q  <= bus.M_dstM;
                w_rd_q    <= acc_go && op.is_rd;
                w_ret_q   <= acc_go && (bus.M_icode == I_RET);
                w_lim_q   <= bus.insn_limit;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.W_stat    = w_stat;
    assign bus.W_icode   = w_icode_q;
    assign bus.W_valE    = w_vale_q;
    assign bus.W_valM    = w_rd_q ? ram_q : '0;
    assign bus.W_dstE    = w_dste_q;
    assign bus.W_dstM    = w_dstm_q;
    assign bus.mem_busy  = (state == ST_ACCESS);

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage against a word-array reference model.
module tb_pipe_mem_stage;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 64;
    localparam int DEPTH   = 4096;
    localparam int MEM_LAT = 2;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_mem_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    pipe_mem_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] ref_mem [DEPTH];
    logic [2:0]  e_stat;
    logic [63:0] e_valm;
    int          e_lat;

    // Reference: architectural effect of one instruction on memory and W.
    function automatic void model(input logic [3:0] icode, input logic [2:0] stat,
                                  input logic [63:0] vala, input logic [63:0] vale,
                                  input logic [63:0] limit);
        logic [63:0] a;
        longint unsigned widx;
        bit rd, wr;
        rd = icode inside {4'd5, 4'd9, 4'd11};
        wr = icode inside {4'd4, 4'd8, 4'd10};
        a = (icode == 4'd9 || icode == 4'd11) ? vala : vale;
        widx = a / 8;
        e_valm = 64'd0;
        e_lat = 1;
        e_stat = 3'b000;
        if (stat != 3'b000) e_stat = stat;
        else if (icode == 4'd0) e_stat = 3'b100;
        else if ((rd || wr) && (widx >= DEPTH || (ALIGN && (a % 8) != 0))) e_stat = 3'b010;
        else if (rd) begin
            e_valm = ref_mem[widx];
            e_lat = MEM_LAT;
            if (icode == 4'd9 && e_valm > limit) e_stat = 3'b010;
        end else if (wr) begin
            ref_mem[widx] = vala;
            e_lat = MEM_LAT;
        end
    endfunction

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_halted();
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.mem_busy !== 1'b0) begin
                errors++;
                $display("FAIL halted cyc=%0d got rdy=%b ov=%b busy=%b want 0 0 0",
                         k, bus.in_ready, bus.out_valid, bus.mem_busy);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Issue one instruction, measure latency, check W, hold for 'hold' cycles, hand off.
    task automatic send(input logic [3:0] icode, input logic [2:0] stat, input logic [63:0] vala,
                        input logic [63:0] vale, input logic [63:0] limit, input int hold);
        logic [3:0] de, dm;
        int n, lat;
        de = 4'($urandom_range(0, 15));
        dm = 4'($urandom_range(0, 15));
        model(icode, stat, vala, vale, limit);
        bus.M_icode = icode; bus.M_stat = stat; bus.M_valA = vala; bus.M_valE = vale;
        bus.M_dstE = de; bus.M_dstM = dm; bus.insn_limit = limit;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout icode=%0d got in_ready=0 want 1", icode);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != e_lat) begin
            errors++; $display("FAIL latency icode=%0d got %0d want %0d", icode, lat, e_lat);
        end
        checks++;
        if (bus.W_stat !== e_stat) begin
            errors++; $display("FAIL W_stat icode=%0d got %b want %b", icode, bus.W_stat, e_stat);
        end
        checks++;
        if (bus.W_icode !== icode || bus.W_valE !== vale || bus.W_dstE !== de || bus.W_dstM !== dm) begin
            errors++;
            $display("FAIL passthru icode=%0d got %0d/%h/%h/%h want %0d/%h/%h/%h", icode,
                     bus.W_icode, bus.W_valE, bus.W_dstE, bus.W_dstM, icode, vale, de, dm);
        end
        if (e_stat == 3'b000) begin
            checks++;
            if (bus.W_valM !== e_valm) begin
                errors++; $display("FAIL W_valM icode=%0d got %h want %h", icode, bus.W_valM, e_valm);
            end
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.W_valE !== vale ||
                bus.W_stat !== e_stat || (e_stat == 3'b000 && bus.W_valM !== e_valm)) begin
                errors++;
                $display("FAIL stall cyc=%0d got ov=%b rdy=%b valE=%h valM=%h want 1 0 %h %h",
                         k, bus.out_valid, bus.in_ready, bus.W_valE, bus.W_valM, vale, e_valm);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL drop_valid icode=%0d got %b want 0", icode, bus.out_valid);
        end
        if (e_stat != 3'b000) begin
            check_halted();
            do_reset();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.mem_busy !== 1'b0 || bus.W_stat !== 3'b000 ||
            bus.W_icode !== 4'h0 || bus.W_valE !== 64'd0 || bus.W_valM !== 64'd0 ||
            bus.W_dstE !== 4'hF || bus.W_dstM !== 4'hF) begin
            errors++;
            $display("FAIL reset_vals got ov=%b busy=%b stat=%b dstE=%h dstM=%h want 0 0 000 f f",
                     bus.out_valid, bus.mem_busy, bus.W_stat, bus.W_dstE, bus.W_dstM);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_store_load();
        send(4'd4, 3'b000, 64'h55, 64'h40, '1, 0);
        send(4'd5, 3'b000, 64'h0, 64'h40, '1, 0);
    endtask

    task automatic test_ret_limit();
        send(4'd9, 3'b000, 64'h10, 64'h0, 64'd2, 0);
    endtask

    task automatic test_stall();
        send(4'd10, 3'b000, 64'hA5A5_0000_1234_5678, 64'h100, '1, 5);
        send(4'd5, 3'b000, 64'h0, 64'h100, '1, 0);
    endtask

    task automatic test_adr();
        send(4'd5, 3'b000, 64'h0, 64'h8000, '1, 0);
    endtask

    task automatic test_align();
        send(4'd5, 3'b000, 64'h0, 64'h41, '1, 0);
    endtask

    task automatic test_stat_pass();
        send(4'd5, 3'b001, 64'h0, 64'h48, '1, 0);
        send(4'd0, 3'b000, 64'h0, 64'h0, '1, 0);
    endtask

    task automatic test_reset_mid_access();
        bus.M_icode = 4'd4; bus.M_stat = 3'b000; bus.M_valA = 64'hDEAD_BEEF;
        bus.M_valE = 64'h80; bus.insn_limit = '1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.mem_busy !== 1'b1) begin
            errors++; $display("FAIL busy_in_access got %b want 1", bus.mem_busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.mem_busy !== 1'b0 || bus.W_dstE !== 4'hF ||
            bus.W_dstM !== 4'hF || bus.W_icode !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset got ov=%b busy=%b dstE=%h icode=%h want 0 0 f 0",
                     bus.out_valid, bus.mem_busy, bus.W_dstE, bus.W_icode);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(4'd5, 3'b000, 64'h0, 64'h80, '1, 0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] v;
        bus.out_ready = 1'b1;
        bus.M_icode = 4'd1; bus.M_stat = 3'b000; bus.insn_limit = '1;
        bus.M_dstE = 4'h3; bus.M_dstM = 4'hF;
        for (int i = 0; i < 4; i++) begin
            v = {$urandom, $urandom};
            bus.M_valE = v;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.W_valE !== v || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b i=%0d got ov=%b valE=%h rdy=%b want 1 %h 1",
                         i, bus.out_valid, bus.W_valE, bus.in_ready, v);
            end
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [11];
        logic [3:0] ic;
        logic [63:0] a, va, ve;
        ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        for (int i = 0; i < 40; i++) begin
            ic = ops[$urandom_range(0, 10)];
            a = 64'($urandom_range(0, 63)) * 64'd8;
            va = {$urandom, $urandom};
            ve = {$urandom, $urandom};
            if (ic == 4'd9 || ic == 4'd11) va = a;
            if (ic inside {4'd4, 4'd5, 4'd8, 4'd10}) ve = a;
            send(ic, 3'b000, va, ve, '1, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'(i + 1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.M_icode = 4'h0; bus.M_stat = 3'b000; bus.M_valA = '0; bus.M_valE = '0;
        bus.M_dstE = 4'hF; bus.M_dstM = 4'hF; bus.insn_limit = '0;
        test_reset();
        test_ret_limit();
        test_store_load();
        test_stall();
        test_reset_mid_access();
        test_adr();
        test_align();
        test_stat_pass();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
